// File: rtl/cnn_stream_pkg.sv
// Shared types and sizing helpers for the CNN streaming blocks.
package cnn_stream_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } fmap_state_e;

  localparam int unsigned DEF_INPUT_WIDTH  = 8;
  localparam int unsigned DEF_NUM_CHANNELS = 2;
  localparam int unsigned PIX   = DEF_INPUT_WIDTH * DEF_INPUT_WIDTH;
  localparam int unsigned TOTAL = PIX * DEF_NUM_CHANNELS;

  // Counter width that never collapses to zero bits for a count of one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fmap_stream_serializer_if.sv
// Frame-load and beat-stream signals of the feature-map serializer.
interface fmap_stream_serializer_if
  import cnn_stream_pkg::*;
#(
  parameter int bitWidth    = 17,
  parameter int inputWidth  = 8,
  parameter int numChannels = 2
) ();

  localparam int unsigned NPIX = inputWidth * inputWidth;
  localparam int unsigned NTOT = NPIX * numChannels;
  localparam int unsigned PW   = cnt_width(NPIX);
  localparam int unsigned CW   = cnt_width(numChannels);

  logic        [bitWidth-1:0] frame_in [NTOT];
  logic                       frame_valid;
  logic                       frame_ready;
  logic signed [bitWidth-1:0] out_pixel;
  logic        [CW-1:0]       out_channel;
  logic        [PW-1:0]       out_index;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;
  logic                       overrun;

  modport master (
    output frame_in, frame_valid, out_ready,
    input  frame_ready, out_pixel, out_channel, out_index, out_valid, out_last, overrun
  );

  modport slave (
    input  frame_in, frame_valid, out_ready,
    output frame_ready, out_pixel, out_channel, out_index, out_valid, out_last, overrun
  );

endinterface

// File: rtl/fmap_stream_serializer_beat_counter.sv
// Pixel/channel beat counter; outputs describe the beat that will be presented next cycle.
module fmap_beat_counter
  import cnn_stream_pkg::*;
#(
  parameter int inputWidth    = 8,
  parameter int numChannels   = 2,
  parameter bit CHANNEL_MAJOR = 1'b0
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         load_i,
  input  logic                                         adv_i,
  output logic [cnt_width(inputWidth*inputWidth*numChannels)-1:0] idx_o,
  output logic [cnt_width(inputWidth*inputWidth)-1:0]  pix_o,
  output logic [cnt_width(numChannels)-1:0]            ch_o,
  output logic                                         last_o
);

  localparam int unsigned NPIX = inputWidth * inputWidth;
  localparam int unsigned NTOT = NPIX * numChannels;
  localparam int unsigned PW   = cnt_width(NPIX);
  localparam int unsigned CW   = cnt_width(numChannels);
  localparam int unsigned IW   = cnt_width(NTOT);

  logic [PW-1:0] pix_q, pix_d;
  logic [CW-1:0] ch_q,  ch_d;
  logic          pix_wrap, ch_wrap;

  assign pix_wrap = (pix_q == PW'(NPIX - 1));
  assign ch_wrap  = (ch_q  == CW'(numChannels - 1));

  // Inner counter is the channel for interleaved order, the pixel for plane order.
  always_comb begin
    pix_d = pix_q;
    ch_d  = ch_q;
    if (load_i) begin
      pix_d = '0;
      ch_d  = '0;
    end else if (adv_i) begin
      if (!CHANNEL_MAJOR) begin
        if (ch_wrap) begin
          ch_d  = '0;
          pix_d = pix_wrap ? '0 : pix_q + PW'(1);
        end else begin
          ch_d  = ch_q + CW'(1);
        end
      end else begin
        if (pix_wrap) begin
          pix_d = '0;
          ch_d  = ch_wrap ? '0 : ch_q + CW'(1);
        end else begin
          pix_d = pix_q + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q <= '0;
      ch_q  <= '0;
    end else begin
      pix_q <= pix_d;
      ch_q  <= ch_d;
    end
  end

  assign pix_o  = pix_d;
  assign ch_o   = ch_d;
  assign idx_o  = IW'(pix_d) * IW'(numChannels) + IW'(ch_d);
  assign last_o = (pix_d == PW'(NPIX - 1)) && (ch_d == CW'(numChannels - 1));

endmodule

// File: rtl/fmap_stream_serializer.sv
// Captures a parallel feature map and replays it one registered beat at a time.
module fmap_stream_serializer
  import cnn_stream_pkg::*;
#(
  parameter int bitWidth      = 17,
  parameter int inputWidth    = 8,
  parameter int numChannels   = 2,
  parameter bit CHANNEL_MAJOR = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  fmap_stream_serializer_if.slave  s
);

  localparam int unsigned NPIX = inputWidth * inputWidth;
  localparam int unsigned NTOT = NPIX * numChannels;
  localparam int unsigned PW   = cnt_width(NPIX);
  localparam int unsigned CW   = cnt_width(numChannels);
  localparam int unsigned IW   = cnt_width(NTOT);

  fmap_state_e                state_q, state_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_last_q;
  logic                       overrun_q;
  logic signed [bitWidth-1:0] out_pixel_q;
  logic        [CW-1:0]       out_channel_q;
  logic        [PW-1:0]       out_index_q;
  logic        [bitWidth-1:0] buf_q [NTOT];

  logic                       frame_ready;
  logic                       xfer, load, adv;
  logic        [IW-1:0]       idx_nxt;
  logic        [PW-1:0]       pix_nxt;
  logic        [CW-1:0]       ch_nxt;
  logic                       last_nxt;
  logic        [bitWidth-1:0] src_word;

  assign xfer        = out_valid_q & s.out_ready;
  assign frame_ready = (state_q == ST_IDLE) | (xfer & out_last_q);
  assign load        = s.frame_valid & frame_ready;
  assign adv         = xfer & ~load;

  fmap_beat_counter #(
    .inputWidth    (inputWidth),
    .numChannels   (numChannels),
    .CHANNEL_MAJOR (CHANNEL_MAJOR)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (reset_n),
    .load_i (load),
    .adv_i  (adv),
    .idx_o  (idx_nxt),
    .pix_o  (pix_nxt),
    .ch_o   (ch_nxt),
    .last_o (last_nxt)
  );

  // Beat 0 of a fresh map comes straight from frame_in, since the buffer fills on the same edge.
  always_comb begin
    src_word = load ? s.frame_in[idx_nxt] : buf_q[idx_nxt];
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    if (load) begin
      state_d     = ST_STREAM;
      out_valid_d = 1'b1;
    end else if (xfer && out_last_q) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      buf_q <= s.frame_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_pixel_q   <= '0;
      out_channel_q <= '0;
      out_index_q   <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      if (load || xfer) begin
        out_pixel_q   <= src_word;
        out_channel_q <= ch_nxt;
        out_index_q   <= pix_nxt;
        out_last_q    <= last_nxt;
      end
      if (s.frame_valid && !frame_ready) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign s.frame_ready = frame_ready;
  assign s.out_valid   = out_valid_q;
  assign s.out_last    = out_last_q;
  assign s.out_pixel   = out_pixel_q;
  assign s.out_channel = out_channel_q;
  assign s.out_index   = out_index_q;
  assign s.overrun     = overrun_q;

endmodule

// File: tb/tb_fmap_stream_serializer.sv
// Directed bench for fmap_stream_serializer: interleaved and plane order, stalls, chaining, overrun, reset.
module tb_fmap_stream_serializer;

  localparam int BW  = 17;
  localparam int IWD = 8;
  localparam int NC  = 2;
  localparam int TOT = IWD * IWD * NC;

  logic clk;
  logic reset_n;
  int   nvec;
  int   nerr;

  fmap_stream_serializer_if #(.bitWidth(BW), .inputWidth(IWD), .numChannels(NC)) if0 ();
  fmap_stream_serializer_if #(.bitWidth(BW), .inputWidth(IWD), .numChannels(NC)) if1 ();

  fmap_stream_serializer #(
    .bitWidth(BW), .inputWidth(IWD), .numChannels(NC), .CHANNEL_MAJOR(1'b0)
  ) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .s       (if0.slave)
  );

  fmap_stream_serializer #(
    .bitWidth(BW), .inputWidth(IWD), .numChannels(NC), .CHANNEL_MAJOR(1'b1)
  ) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .s       (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill0(input int base);
    for (int i = 0; i < TOT; i++) if0.frame_in[i] = BW'(base + i);
  endtask

  // Presents frame_in[i]=base+i on dut0 for exactly one load edge.
  task automatic load0(input int base);
    @(negedge clk);
    fill0(base);
    if0.out_ready   = 1'b1;
    if0.frame_valid = 1'b1;
    #1;
    check("idle_ready", if0.frame_ready, 1);
    check("pre_valid", if0.out_valid, 0);
    @(posedge clk);
    #1 if0.frame_valid = 1'b0;
  endtask

  // mode 0 plain, 1 chain next frame (base 1000) on last beat, 2 frame pulse at ev, 3 reset at ev.
  task automatic stream0(input int base, input int stall_at, input int stall_n,
                         input int ev, input int mode);
    int   k;
    int   stalls;
    int   cyc;
    logic rdy;
    k = 0; stalls = 0; cyc = 0;
    while (k < TOT) begin
      @(negedge clk);
      cyc++;
      if (cyc > 400) begin
        check("stream_timeout", cyc, 400);
        return;
      end
      check("valid", if0.out_valid, 1);
      check("pixel", if0.out_pixel, base + k);
      check("channel", if0.out_channel, k % 2);
      check("index", if0.out_index, k / 2);
      check("last", if0.out_last, (k == TOT - 1) ? 1 : 0);
      if (k == stall_at && stalls < stall_n) begin
        rdy = 1'b0;
        stalls++;
      end else begin
        rdy = 1'b1;
      end
      if0.out_ready = rdy;
      if (mode == 1 && k == TOT - 1) begin
        fill0(1000);
        if0.frame_valid = 1'b1;
        #1 check("chain_ready", if0.frame_ready, 1);
      end
      if (mode == 2 && k == ev) begin
        fill0(500);
        if0.frame_valid = 1'b1;
        #1 check("busy_ready", if0.frame_ready, 0);
      end
      if (mode == 3 && k == ev) begin
        reset_n = 1'b0;
        #1;
        check("rst_valid", if0.out_valid, 0);
        check("rst_pixel", if0.out_pixel, 0);
        check("rst_last", if0.out_last, 0);
        return;
      end
      @(posedge clk);
      #1 if0.frame_valid = 1'b0;
      if (rdy) k++;
    end
    if (mode != 1) begin
      @(negedge clk);
      check("end_valid", if0.out_valid, 0);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    reset_n = 1'b1;
    if0.frame_valid = 1'b0; if0.out_ready = 1'b0;
    if1.frame_valid = 1'b0; if1.out_ready = 1'b0;
    for (int i = 0; i < TOT; i++) begin
      if0.frame_in[i] = '0;
      if1.frame_in[i] = BW'(i);
    end
    #2 reset_n = 1'b0;
    #3;
    check("rst_out_valid", if0.out_valid, 0);
    check("rst_out_pixel", if0.out_pixel, 0);
    check("rst_out_last", if0.out_last, 0);
    check("rst_out_channel", if0.out_channel, 0);
    check("rst_out_index", if0.out_index, 0);
    check("rst_overrun", if0.overrun, 0);
    check("rst_frame_ready", if0.frame_ready, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Interleaved order, consumer always ready.
    load0(0);
    stream0(0, -1, 0, -1, 0);

    // Plane order on dut1: even array indices (channel 0) first, then odd.
    @(negedge clk);
    if1.out_ready   = 1'b1;
    if1.frame_valid = 1'b1;
    @(posedge clk);
    #1 if1.frame_valid = 1'b0;
    for (int k = 0; k < TOT; k++) begin
      @(negedge clk);
      check("cm1_valid", if1.out_valid, 1);
      check("cm1_pixel", if1.out_pixel, (k < 64) ? 2 * k : 2 * (k - 64) + 1);
      check("cm1_channel", if1.out_channel, (k < 64) ? 0 : 1);
      check("cm1_index", if1.out_index, k % 64);
      check("cm1_last", if1.out_last, (k == TOT - 1) ? 1 : 0);
    end
    @(negedge clk);
    check("cm1_end_valid", if1.out_valid, 0);

    // Three-cycle stall while beat 5 is presented.
    load0(0);
    stream0(0, 5, 3, -1, 0);

    // Second map held valid across the last beat: no bubble, no overrun.
    load0(0);
    stream0(0, -1, 0, -1, 1);
    stream0(1000, -1, 0, -1, 0);
    check("chain_overrun", if0.overrun, 0);

    // Frame offered mid-stream at beat 30: ignored, overrun sticks.
    load0(0);
    stream0(0, -1, 0, 30, 2);
    check("overrun_set", if0.overrun, 1);
    repeat (3) @(negedge clk);
    check("overrun_sticky", if0.overrun, 1);

    // Reset during beat 40, then a fresh load streams from value 0.
    load0(0);
    stream0(0, -1, 0, 40, 3);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", if0.frame_ready, 1);
    check("post_rst_overrun", if0.overrun, 0);
    check("post_rst_valid", if0.out_valid, 0);
    load0(0);
    stream0(0, -1, 0, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fmap_stream_serializer.md
Name: fmap_stream_serializer

Overview:
- Reverse side of the conv2D output stage. The conv stage delivers a whole feature map as a parallel flat array, indexed pixel*numChannels + channel.
- This block captures that array on a load handshake and replays it one value per beat over a valid/ready stream.
- Sits between the conv/ReLU layer and any downstream streaming consumer (next conv input, pooling, dense).

Parameters:
- bitWidth, 17, signed fixed-point word width.
- inputWidth, 8, feature-map side length; pixels per channel = inputWidth*inputWidth.
- numChannels, 2, filters per pixel (matches the conv layer's biasWidth).
- CHANNEL_MAJOR, 0, emission order. 0 = array index order, channels interleaved. 1 = plane by plane: channel 0 for all pixels, then channel 1, and so on.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- frame_in  in  [bitWidth-1:0] x TOTAL, with TOTAL = inputWidth*inputWidth*numChannels  parallel feature map, flat index p*numChannels+c
- frame_valid  in  1  frame_in holds a complete map
- frame_ready  out  1  block can capture a map this cycle
- out_pixel  out  signed [bitWidth-1:0]  streamed value
- out_channel  out  [$clog2(numChannels)-1:0]  channel of out_pixel (width 1 when numChannels=1)
- out_index  out  [$clog2(inputWidth*inputWidth)-1:0]  pixel index p of out_pixel
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts beat
- out_last  out  1  final beat of frame
- overrun  out  1  sticky: a frame was offered while the block was busy

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, beat counter=0.
  - out_valid, out_last, out_pixel, out_channel, out_index and overrun all 0.
  - Capture buffer is not reset.
- FSM IDLE:
  - frame_ready=1.
  - frame_valid=1: copy frame_in into the capture buffer, counter=0, go to STREAM.
  - out_valid rises the next cycle (1-cycle latency), carrying beat 0.
- FSM STREAM:
  - out_* are registered and present beat k.
  - Beat transfers when out_valid && out_ready; counter advances and the next beat is registered for the following cycle.
  - out_valid && !out_ready: all out_* hold stable. No skip, no duplicate.
- Beat k to array index:
  - CHANNEL_MAJOR=0: index = k, so out_index = k / numChannels and out_channel = k % numChannels.
  - CHANNEL_MAJOR=1: c = k / (inputWidth^2), p = k % (inputWidth^2), index = p*numChannels + c.
  - Implement with separate pixel and channel counters; no divider.
- out_last=1 only on beat TOTAL-1.
- After the last beat transfers:
  - frame_valid=0 that cycle: go to IDLE, out_valid=0 next cycle.
  - frame_valid=1 that cycle: frame_ready is combinationally 1 (frame_ready = IDLE || (out_valid && out_ready && out_last)). The new map is captured and beat 0 of it appears the next cycle with no bubble.
- frame_valid=1 in STREAM other than on the last transferring beat:
  - frame_ready=0 and the map is ignored.
  - overrun sets and stays set until reset.
  - The current stream is unaffected.
- Values are passed through unmodified, with no saturation or rounding. ReLU has already been applied upstream.
- reset_n asserted mid-stream: outputs clear immediately and the partial frame is discarded. After release, state is IDLE with frame_ready=1.

Decomposition:
- Shared package cnn_stream_pkg holds:
  - fmap state enum (IDLE, STREAM)
  - localparams TOTAL and PIX = inputWidth*inputWidth
  - counter width functions
- One sub-module, fmap_beat_counter: pixel and channel counters with ordering per CHANNEL_MAJOR. Outputs flat index, out_index, out_channel and last flag; advance enable.
- Capture buffer and output mux stay in the top module.

Test Plan:
All scenarios use defaults (inputWidth=8, numChannels=2, TOTAL=128) with frame_in[i]=i.
- Load at cycle N with out_ready=1 -> out_valid over cycles N+1..N+128. Values are 0..127. out_channel alternates 0,1 and out_index = k/2. out_last only at value 127, and out_valid=0 at N+129.
- CHANNEL_MAJOR=1, same stimulus -> values 0,2,…,126 with out_channel=0 and out_index 0..63, then 1,3,…,127 with out_channel=1. out_last on value 127.
- out_ready=0 for 3 cycles while beat 5 is presented -> out_pixel holds 5 with out_valid=1. Then 5,6,7… with no gap or duplicate; total 128 beats.
- Second frame (frame_in[i]=1000+i) held valid across A's last beat -> frame_ready=1 on that cycle. Value 1000 appears the cycle after 127 with no bubble; overrun stays 0.
- frame_valid pulse at beat 30 -> frame_ready=0, overrun=1 permanently. Beats 30..127 still carry the original values.
- reset_n low during beat 40 -> out_valid and out_pixel drop to 0 asynchronously. After release frame_ready=1, and a fresh load streams from value 0.
